uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter: serialises bytes onto TXD as 8N1 frames (start, 8 data LSB-first, stop).
//  Sits beside the UART receive path in the chip top; returns logs/results to the host.
//  Upstream logic hands it bytes over a valid/ready handshake.
// PARAMETERS
//  CLKS_PER_BIT  87  CLK cycles per bit period (10 MHz / 115200 baud); legal range >= 2
// PORTS
//  CLK       in   1  system clock; all logic on rising edge
//  RESET     in   1  synchronous, active-high reset
//  tx_data   in   8  byte to send; sampled only on the accept edge
//  tx_valid  in   1  upstream has a byte on tx_data
//  tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready at a rising edge
//  TXD       out  1  serial line; idle high; registered output (no glitches)
//  tx_busy   out  1  high while a frame is in flight (START/DATA/STOP)
//  tx_done   out  1  one-cycle pulse when the stop bit completes
// BEHAVIOUR
//  Reset: state=IDLE, TXD=1, tx_ready=1, tx_busy=0, tx_done=0, bit counter=0, baud counter=0.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: TXD=1. On accept edge k: latch tx_data into shift reg; state=START; TXD=0 from k.
//   START: hold TXD=0 for CLKS_PER_BIT cycles, then DATA with TXD=shift[0].
//   DATA: each bit held CLKS_PER_BIT cycles; shift right; 3-bit index 0..7;
//         after bit 7's period -> STOP, TXD=1.
//   STOP: hold TXD=1 for CLKS_PER_BIT cycles; at the final edge (k+10*CLKS_PER_BIT):
//         state=IDLE, tx_done=1 for exactly one cycle, tx_ready=1.
//  Timing: TXD falling edge coincides with the accept edge (latency 0 cycles after accept).
//   Each bit is exactly CLKS_PER_BIT cycles; frame is 10*CLKS_PER_BIT cycles.
//  Back-to-back: tx_ready is high in the cycle tx_done is high. If tx_valid is held,
//   the next accept happens at edge k+10*CLKS_PER_BIT+1.
//   The stop bit therefore lasts CLKS_PER_BIT+1 cycles between consecutive frames.
//  Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
//   Cleared on accept; never free-runs in IDLE.
//  tx_valid while busy: ignored; no queueing. tx_data changes mid-frame: no effect.
//  tx_valid dropped mid-frame: frame completes normally.
//  RESET mid-frame: at the next edge with RESET=1, the frame aborts and TXD=1.
//   Reset values apply and no tx_done is issued.
//   RESET has priority over a simultaneous accept.
//  tx_busy = (state != IDLE); tx_ready = (state == IDLE) & ~RESET-driven state.
// STRUCTURE
//  Package neurocore_uart_pkg: uart_state_t enum (IDLE, START, DATA, STOP),
//   UART_DATA_BITS=8, UART_FRAME_BITS=10, default CLKS_PER_BIT.
//   The same package is shared with the receive path.
//  Sub-module uart_baud_gen: parameterised bit-period counter with clear input and tick output.
//   It is reused by the receiver.
//  uart_tx holds the FSM, the shift register, the bit index and the registered TXD.
// TESTING (CLKS_PER_BIT=4 for speed, plus one run at 87)
//  Send 0xA5 once: TXD = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
//   Expect tx_done at accept+40 and tx_busy high for 40 cycles.
//  Hold tx_valid with 0x00 then 0xFF: the second accept lands exactly 41 cycles after the first.
//   Bench decodes both bytes correctly.
//  Pulse tx_valid with 0x3C while busy: ignored; only the original byte appears on TXD.
//   tx_ready stays 0 until tx_done.
//  Assert RESET at cycle 15 of a frame: TXD=1 on the next edge; tx_ready=1; no tx_done.
//   A new send of 0x81 then serialises cleanly.
//  Change tx_data to 0x55 one cycle after accepting 0x0F: the line still carries 0x0F.
//  Scoreboard: a UART RX bench model sampling at mid-bit matches 256 random bytes.
//   Framing error count must be 0.

Source files
------------

// File: rtl/neurocore_uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package neurocore_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_FRAME_BITS   = 10;
  localparam int unsigned UART_CLKS_PER_BIT = 87;  // 10 MHz / 115200 baud

  // Width of a counter spanning 0..clks-1 (at least one bit).
  function automatic int unsigned uart_cnt_width(input int unsigned clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on the last count.
module uart_baud_gen
  import neurocore_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned      CNT_W = uart_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i & (cnt_q == LAST);

  // Counter holds while disabled, wraps at each bit boundary, clears on request.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, valid/ready byte input, registered TXD.
module uart_tx
  import neurocore_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      TXD,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [2:0]                bit_idx_q;
  logic                      txd_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      accept;
  logic                      baud_tick;

  assign accept   = tx_valid & ready_q;
  assign tx_ready = ready_q;
  assign TXD      = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  // Counter is cleared on accept so the start bit is a full period; it only runs mid-frame.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (accept),
    .en_i  (busy_q),
    .tick_o(baud_tick)
  );

  // Frame sequencer with registered line, handshake and status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= tx_data;
            state_q <= START;
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            state_q   <= DATA;
            txd_q     <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx_q == LAST_BIT) begin
              state_q   <= STOP;
              txd_q     <= 1'b1;
              bit_idx_q <= '0;
            end else begin
              // Drive the next bit from shift_q[1] in the same edge the register shifts.
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4 and 87, with a mid-bit sampling RX model.
module tb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned CPB87 = 87;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, tx_data87;
  logic       tx_valid, tx_valid87;
  logic       tx_ready, txd, tx_busy, tx_done;
  logic       tx_ready87, txd87, tx_busy87, tx_done87;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .CLK(clk), .RESET(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .TXD(txd), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB87)) u_dut87 (
    .CLK(clk), .RESET(rst), .tx_data(tx_data87), .tx_valid(tx_valid87),
    .tx_ready(tx_ready87), .TXD(txd87), .tx_busy(tx_busy87), .tx_done(tx_done87)
  );

  // Line level of bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  // RX model: detects the start edge, samples each bit at mid-period.
  logic       sb_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_framing_err = 0;

  initial begin
    logic        rx_active;
    int unsigned rx_phase;
    int unsigned bit_n;
    logic [7:0]  rx_shift;
    rx_active = 1'b0;
    rx_phase  = 0;
    rx_shift  = '0;
    forever begin
      @(negedge clk);
      if (!sb_en || rst) begin
        rx_active = 1'b0;
      end else begin
        if (rx_active) begin
          rx_phase = rx_phase + 1;
        end else if (txd == 1'b0) begin
          rx_active = 1'b1;
          rx_phase  = 0;
        end
        if (rx_active && (rx_phase % CPB) == CPB / 2) begin
          bit_n = rx_phase / CPB;
          if (bit_n == 0) begin
            if (txd !== 1'b0) begin
              rx_framing_err++;
              rx_active = 1'b0;
            end
          end else if (bit_n <= 8) begin
            rx_shift[bit_n-1] = txd;
          end else begin
            if (txd !== 1'b1) rx_framing_err++;
            rx_q.push_back(rx_shift);
            rx_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_in got={txd,busy,ready,done}=%b exp=1010", {txd, tx_busy, tx_ready, tx_done});
    end
    checks++;
    if ({txd87, tx_busy87, tx_ready87, tx_done87} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_in87 got=%b exp=1010", {txd87, tx_busy87, tx_ready87, tx_done87});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({txd, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=1010", {txd, tx_busy, tx_ready, tx_done});
    end
  endtask

  task automatic test_single_a5();
    logic [3:0] exp;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    for (int j = 0; j <= 41; j++) begin
      @(negedge clk);
      if (j == 0) tx_valid = 1'b0;
      if (j < 40)       exp = {frame_bit(8'hA5, j / CPB), 3'b100};
      else if (j == 40) exp = 4'b1011;
      else              exp = 4'b1010;
      checks++;
      if ({txd, tx_busy, tx_ready, tx_done} !== exp) begin
        failures++;
        $display("FAIL a5 j=%0d got={txd,busy,ready,done}=%b exp=%b", j, {txd, tx_busy, tx_ready, tx_done}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    logic       samp[0:81];
    logic [7:0] d0, d1;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int j = 0; j <= 81; j++) begin
      @(negedge clk);
      if (j == 0)  tx_data  = 8'hFF;
      if (j == 41) tx_valid = 1'b0;
      if (j < 40)       exp = {frame_bit(8'h00, j / CPB), 3'b100};
      else if (j == 40) exp = 4'b1011;
      else if (j < 81)  exp = {frame_bit(8'hFF, (j - 41) / CPB), 3'b100};
      else              exp = 4'b1011;
      samp[j] = txd;
      checks++;
      if ({txd, tx_busy, tx_ready, tx_done} !== exp) begin
        failures++;
        $display("FAIL b2b j=%0d got=%b exp=%b", j, {txd, tx_busy, tx_ready, tx_done}, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      d0[i] = samp[CPB * (i + 1) + CPB / 2];
      d1[i] = samp[41 + CPB * (i + 1) + CPB / 2];
    end
    checks++;
    if (d0 !== 8'h00) begin
      failures++;
      $display("FAIL b2b_byte0 got=%h exp=00", d0);
    end
    checks++;
    if (d1 !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_byte1 got=%h exp=ff", d1);
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0] exp;
    @(negedge clk);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    for (int j = 0; j <= 42; j++) begin
      @(negedge clk);
      if (j == 0)  tx_valid = 1'b0;
      if (j == 10) begin tx_data = 8'h3C; tx_valid = 1'b1; end
      if (j == 11) tx_valid = 1'b0;
      if (j < 40)       exp = {frame_bit(8'h96, j / CPB), 3'b100};
      else if (j == 40) exp = 4'b1011;
      else              exp = 4'b1010;
      checks++;
      if ({txd, tx_busy, tx_ready, tx_done} !== exp) begin
        failures++;
        $display("FAIL ignore j=%0d got=%b exp=%b", j, {txd, tx_busy, tx_ready, tx_done}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    for (int j = 0; j <= 60; j++) begin
      @(negedge clk);
      if (j == 0) tx_valid = 1'b0;
      if (j < 16) exp = {frame_bit(8'hC3, j / CPB), 3'b100};
      else        exp = 4'b1010;
      checks++;
      if ({txd, tx_busy, tx_ready, tx_done} !== exp) begin
        failures++;
        $display("FAIL rstmid j=%0d got=%b exp=%b", j, {txd, tx_busy, tx_ready, tx_done}, exp);
      end
      if (j == 15) rst = 1'b1;
      if (j == 16) rst = 1'b0;
    end
    // Reset wins over an accept presented in the same cycle.
    @(negedge clk);
    rst      = 1'b1;
    tx_data  = 8'hE7;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    rst      = 1'b0;
    checks++;
    if ({txd, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
      failures++;
      $display("FAIL rst_prio got=%b exp=1010", {txd, tx_busy, tx_ready, tx_done});
    end
    @(negedge clk);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    for (int j = 0; j <= 41; j++) begin
      @(negedge clk);
      if (j == 0) tx_valid = 1'b0;
      if (j < 40)       exp = {frame_bit(8'h81, j / CPB), 3'b100};
      else if (j == 40) exp = 4'b1011;
      else              exp = 4'b1010;
      checks++;
      if ({txd, tx_busy, tx_ready, tx_done} !== exp) begin
        failures++;
        $display("FAIL after_rst81 j=%0d got=%b exp=%b", j, {txd, tx_busy, tx_ready, tx_done}, exp);
      end
    end
  endtask

  task automatic test_data_change();
    logic [3:0] exp;
    @(negedge clk);
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (j == 0) begin tx_valid = 1'b0; tx_data = 8'h55; end
      if (j < 40) exp = {frame_bit(8'h0F, j / CPB), 3'b100};
      else        exp = 4'b1011;
      checks++;
      if ({txd, tx_busy, tx_ready, tx_done} !== exp) begin
        failures++;
        $display("FAIL datachg j=%0d got=%b exp=%b", j, {txd, tx_busy, tx_ready, tx_done}, exp);
      end
    end
  endtask

  task automatic test_scoreboard();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         waited;
    int         n_cmp;
    rx_q.delete();
    rx_framing_err = 0;
    @(negedge clk);
    sb_en = 1'b1;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      waited = 0;
      while (tx_done !== 1'b1 && waited < 60) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (tx_done !== 1'b1) begin
        failures++;
        $display("FAIL sb_done_timeout n=%0d got=%b exp=1", n, tx_done);
      end
    end
    repeat (3) @(negedge clk);
    sb_en = 1'b0;
    checks++;
    if (rx_q.size() != 256) begin
      failures++;
      $display("FAIL sb_count got=%0d exp=256", rx_q.size());
    end
    n_cmp = (rx_q.size() < 256) ? rx_q.size() : 256;
    for (int i = 0; i < n_cmp; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL sb_byte i=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rx_framing_err != 0) begin
      failures++;
      $display("FAIL sb_framing got=%0d exp=0", rx_framing_err);
    end
  endtask

  task automatic test_cpb87();
    logic [3:0] exp;
    @(negedge clk);
    tx_data87  = 8'h5A;
    tx_valid87 = 1'b1;
    for (int j = 0; j <= 10 * CPB87 + 1; j++) begin
      @(negedge clk);
      if (j == 0) tx_valid87 = 1'b0;
      if (j < 10 * CPB87)       exp = {frame_bit(8'h5A, j / CPB87), 3'b100};
      else if (j == 10 * CPB87) exp = 4'b1011;
      else                      exp = 4'b1010;
      checks++;
      if ({txd87, tx_busy87, tx_ready87, tx_done87} !== exp) begin
        failures++;
        $display("FAIL cpb87 j=%0d got=%b exp=%b", j, {txd87, tx_busy87, tx_ready87, tx_done87}, exp);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    tx_data    = '0;
    tx_valid   = 1'b0;
    tx_data87  = '0;
    tx_valid87 = 1'b0;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_data_change();
    test_scoreboard();
    test_cpb87();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
